// File: rtl/muldiv_unit.sv
// RV32M-style iterative multiply/divide unit: one bit per cycle,
// shift-add multiply and restoring divide on operand magnitudes.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            illegal
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          r_state;
   state_t          w_next;
   logic [XLEN-1:0] r_hi;
   logic [XLEN-1:0] r_lo;
   logic [XLEN-1:0] r_md;
   logic [XLEN-1:0] r_result;
   logic [2:0]      r_f3;
   logic            r_sneg;
   logic            r_rneg;
   logic            r_illegal;
   logic [CW-1:0]   r_cnt;

   logic            w_accept;
   logic            w_legal;
   logic            w_sa;
   logic            w_sb;
   logic            w_a_neg;
   logic            w_b_neg;
   logic [XLEN-1:0] w_abs_a;
   logic [XLEN-1:0] w_abs_b;
   logic            w_dz;
   logic            w_ovf;
   logic            w_special;
   logic [XLEN-1:0] w_spec_res;
   logic            w_last;

   logic [XLEN:0]     w_sum;
   logic [XLEN:0]     w_shl;
   logic [XLEN:0]     w_diff;
   logic              w_qbit;
   logic [XLEN-1:0]   w_nhi;
   logic [XLEN-1:0]   w_nlo;
   logic [2*XLEN-1:0] w_prod;
   logic [2*XLEN-1:0] w_prod_s;
   logic [XLEN-1:0]   w_quo;
   logic [XLEN-1:0]   w_rem;
   logic [XLEN-1:0]   w_calc_res;

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign result    = r_result;
   assign illegal   = r_illegal;

   assign w_accept = in_valid && in_ready;
   assign w_legal  = (funct7 == 7'b0000001);

   // Signed operand interpretation per funct3
   assign w_sa = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
   assign w_sb = (funct3 == 3'b001) || (funct3 == 3'b100) ||
                 (funct3 == 3'b110);

   assign w_a_neg = w_sa && op_a[XLEN-1];
   assign w_b_neg = w_sb && op_b[XLEN-1];
   assign w_abs_a = w_a_neg ? (~op_a + 1'b1) : op_a;
   assign w_abs_b = w_b_neg ? (~op_b + 1'b1) : op_b;

   assign w_dz  = funct3[2] && (op_b == '0);
   assign w_ovf = funct3[2] && !funct3[0] &&
                  (op_a == MIN) && (op_b == '1);
   assign w_special = !w_legal || w_dz || w_ovf;

   always_comb begin
      w_spec_res = '0;
      if (!w_legal)
         w_spec_res = '0;
      else if (w_dz)
         w_spec_res = funct3[1] ? op_a : '1;
      else if (w_ovf)
         w_spec_res = funct3[1] ? '0 : op_a;
   end

   // One iteration step of either algorithm
   assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_md} : '0);
   assign w_shl  = {r_hi, r_lo[XLEN-1]};
   assign w_diff = w_shl - {1'b0, r_md};
   assign w_qbit = !w_diff[XLEN];

   assign w_nhi = r_f3[2] ?
                  (w_qbit ? w_diff[XLEN-1:0] : w_shl[XLEN-1:0]) :
                  w_sum[XLEN:1];
   assign w_nlo = r_f3[2] ?
                  {r_lo[XLEN-2:0], w_qbit} :
                  {w_sum[0], r_lo[XLEN-1:1]};

   assign w_prod   = {w_nhi, w_nlo};
   assign w_prod_s = r_sneg ? (~w_prod + 1'b1) : w_prod;
   assign w_quo    = r_sneg ? (~w_nlo + 1'b1) : w_nlo;
   assign w_rem    = r_rneg ? (~w_nhi + 1'b1) : w_nhi;
   assign w_last   = (r_cnt == CW'(XLEN-1));

   always_comb begin
      w_calc_res = '0;
      unique case (r_f3)
         3'b000:  w_calc_res = w_prod_s[XLEN-1:0];
         3'b001,
         3'b010,
         3'b011:  w_calc_res = w_prod_s[2*XLEN-1:XLEN];
         3'b100,
         3'b101:  w_calc_res = w_quo;
         default: w_calc_res = w_rem;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: if (w_accept) w_next = w_special ? DONE : CALC;
         CALC: if (w_last) w_next = DONE;
         DONE: if (out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hi      <= '0;
         r_lo      <= '0;
         r_md      <= '0;
         r_result  <= '0;
         r_f3      <= '0;
         r_sneg    <= 1'b0;
         r_rneg    <= 1'b0;
         r_illegal <= 1'b0;
         r_cnt     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_f3   <= funct3;
                  r_hi   <= '0;
                  r_lo   <= w_abs_a;
                  r_md   <= w_abs_b;
                  r_sneg <= w_a_neg ^ w_b_neg;
                  r_rneg <= w_a_neg;
                  r_cnt  <= '0;
                  if (w_special) begin
                     r_result  <= w_spec_res;
                     r_illegal <= !w_legal;
                  end
               end
            end
            CALC: begin
               r_hi  <= w_nhi;
               r_lo  <= w_nlo;
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_result  <= w_calc_res;
                  r_illegal <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
